// File: rtl/hdd_spinup_sched.sv
`default_nettype none
// ============================================================================
// Module   : hdd_spinup_sched
// Purpose  : Staggered spin-up scheduler for HDD power rails. Grants pending
//            power-on requests in round-robin order. At most MAX_CONC drives
//            are in their inrush (SPINUP) window at once. Power-off requests
//            take effect on the next edge and are never arbitrated.
// Ports    : SYSCLK     - system clock, rising edge
//            RESET      - synchronous, active-high reset
//            TICK       - one-cycle timebase strobe (1 Hz)
//            REQ_ON     - per-drive power request, 1 = want on
//            PWR_EN_L   - per-drive power enable, active-low
//            SPINUP_CNT - registered count of drives in SPINUP
//            PEND       - registered mask of requesting drives still OFF
//            BUSY       - spin-up in progress or requests pending
// Revision : 1.0 - initial release
// ============================================================================
module hdd_spinup_sched #(
  parameter int NUM_HDD      = 15,
  parameter int MAX_CONC     = 2,
  parameter int SPINUP_TICKS = 4
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic               TICK,
  input  logic [NUM_HDD-1:0] REQ_ON,
  output logic [NUM_HDD-1:0] PWR_EN_L,
  output logic [4:0]         SPINUP_CNT,
  output logic [NUM_HDD-1:0] PEND,
  output logic               BUSY
);

  localparam int PTR_W = $clog2(NUM_HDD);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SPINUP = 2'd1,
    ST_ON     = 2'd2
  } drv_state_e;

  drv_state_e         state_q [NUM_HDD];
  drv_state_e         state_d [NUM_HDD];
  logic [3:0]         timer_q [NUM_HDD];
  logic [3:0]         timer_d [NUM_HDD];
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [4:0]         spinup_cnt_q, spinup_cnt_d;
  logic [NUM_HDD-1:0] pend_q, pend_d;
  logic               grant_q;

  logic [NUM_HDD-1:0] cand;
  logic [NUM_HDD-1:0] grant_oh;
  logic               grant_ok;
  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  int                 rr_idx;
  int                 nxt_ptr;

  // Arbitration. SPINUP_CNT is a registered popcount, so a drive granted on
  // the previous edge is already in SPINUP but not yet counted. Adding the
  // previous-cycle grant keeps back-to-back grants from overshooting
  // MAX_CONC while the count catches up.
  always_comb begin
    cand      = '0;
    grant_oh  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    nxt_ptr   = 0;
    rr_ptr_d  = rr_ptr_q;

    for (int i = 0; i < NUM_HDD; i++) begin
      cand[i] = REQ_ON[i] && (state_q[i] == ST_OFF);
    end

    grant_ok = (int'(spinup_cnt_q) + int'(grant_q)) < MAX_CONC;

    if (grant_ok) begin
      for (int off = 0; off < NUM_HDD; off++) begin
        rr_idx = int'(rr_ptr_q) + off;
        if (rr_idx >= NUM_HDD) begin
          rr_idx = rr_idx - NUM_HDD;
        end
        if (!grant_vld && cand[PTR_W'(rr_idx)]) begin
          grant_vld = 1'b1;
          grant_idx = PTR_W'(rr_idx);
        end
      end
    end

    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
      nxt_ptr  = int'(grant_idx) + 1;
      rr_ptr_d = (nxt_ptr >= NUM_HDD) ? '0 : PTR_W'(nxt_ptr);
    end
  end

  // Per-drive state machines and the SPINUP population count.
  always_comb begin
    spinup_cnt_d = '0;
    pend_d       = cand & ~grant_oh;
    for (int i = 0; i < NUM_HDD; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      if (state_q[i] == ST_SPINUP) begin
        spinup_cnt_d = spinup_cnt_d + 5'd1;
      end
      case (state_q[i])
        ST_OFF: begin
          if (grant_oh[i]) begin
            // Load on the grant edge even if TICK is high: the window is
            // SPINUP_TICKS full ticks after the grant.
            state_d[i] = ST_SPINUP;
            timer_d[i] = 4'(SPINUP_TICKS);
          end
        end
        ST_SPINUP: begin
          if (!REQ_ON[i]) begin
            state_d[i] = ST_OFF;
            timer_d[i] = 4'd0;
          end else if (TICK) begin
            if (timer_q[i] == 4'd1) begin
              state_d[i] = ST_ON;
              timer_d[i] = 4'd0;
            end else begin
              timer_d[i] = timer_q[i] - 4'd1;
            end
          end
        end
        ST_ON: begin
          if (!REQ_ON[i]) begin
            state_d[i] = ST_OFF;
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          timer_d[i] = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_HDD; i++) begin
        state_q[i] <= ST_OFF;
        timer_q[i] <= 4'd0;
      end
      rr_ptr_q     <= '0;
      spinup_cnt_q <= '0;
      pend_q       <= '0;
      grant_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_HDD; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      rr_ptr_q     <= rr_ptr_d;
      spinup_cnt_q <= spinup_cnt_d;
      pend_q       <= pend_d;
      grant_q      <= grant_vld;
    end
  end

  // Enables decode straight from the state registers.
  for (genvar g = 0; g < NUM_HDD; g++) begin : g_pwr_en
    assign PWR_EN_L[g] = (state_q[g] == ST_OFF);
  end

  assign SPINUP_CNT = spinup_cnt_q;
  assign PEND       = pend_q;
  assign BUSY       = (spinup_cnt_q != 5'd0) || (pend_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_hdd_spinup_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdd_spinup_sched
// Purpose  : Self-checking bench for hdd_spinup_sched (default parameters).
//            Expected grant order is queued as stimulus is applied; a monitor
//            pops and compares each time a PWR_EN_L bit falls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdd_spinup_sched;

  localparam int          N   = 15;
  localparam logic [14:0] ALL = 15'h7FFF;

  logic          clk;
  logic          rst;
  logic          tick;
  logic [N-1:0]  req;
  logic [N-1:0]  pwr_en_l;
  logic [4:0]    spinup_cnt;
  logic [N-1:0]  pend;
  logic          busy;

  int            checks;
  int            failures;
  int            cyc_cnt;
  bit            tick_auto;
  bit            mon_en;
  logic [N-1:0]  prev_pwr;
  int            exp_q[$];

  hdd_spinup_sched #(
    .NUM_HDD      (N),
    .MAX_CONC     (2),
    .SPINUP_TICKS (4)
  ) dut (
    .SYSCLK     (clk),
    .RESET      (rst),
    .TICK       (tick),
    .REQ_ON     (req),
    .PWR_EN_L   (pwr_en_l),
    .SPINUP_CNT (spinup_cnt),
    .PEND       (pend),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Monitor: every falling PWR_EN_L bit is a grant and must match the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        if (prev_pwr[i] && !pwr_en_l[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL grant_unexpected: got grant to drive %0d, expected no grant", i);
          end else begin
            if (exp_q[0] != i) begin
              failures++;
              $display("FAIL grant_order: got drive %0d, expected drive %0d", i, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
        end
      end
      checks++;
      if (spinup_cnt > 5'd2) begin
        failures++;
        $display("FAIL spinup_limit: got SPINUP_CNT %0d, expected at most 2", spinup_cnt);
      end
    end
    prev_pwr = pwr_en_l;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    tick = tick_auto && (cyc_cnt % 10 == 0);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    step();
    step();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    tick_auto = 1'b0;
    tick      = 1'b0;
    steps(2);
    rst = 1'b0;
    step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc_cnt   = 0;
    tick_auto = 1'b0;
    mon_en    = 1'b0;
    prev_pwr  = ALL;
    rst       = 1'b1;
    tick      = 1'b0;
    req       = ALL;

    // ---- Reset with every drive requesting ----
    step();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("reset_pwr_en_l", 32'(pwr_en_l), 32'(ALL));
      chk("reset_spinup_cnt", 32'(spinup_cnt), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      step();
    end
    mon_en = 1'b1;
    rst    = 1'b0;
    req    = '0;
    steps(2);

    // ---- Stagger: all 15 drives request, TICK every 10 cycles ----
    for (int i = 0; i < N; i++) exp_q.push_back(i);
    req       = ALL;
    tick_auto = 1'b1;
    step();
    sample();
    chk("stagger_first", 32'(pwr_en_l), 32'h7FFE);
    step();
    sample();
    chk("stagger_second", 32'(pwr_en_l), 32'h7FFC);
    steps(5);
    sample();
    chk("stagger_hold", 32'(pwr_en_l), 32'h7FFC);
    chk("stagger_cnt2", 32'(spinup_cnt), 32'd2);
    chk("stagger_pend", 32'(pend), 32'h7FFC);
    chk("stagger_busy", 32'(busy), 32'd1);
    begin
      int n;
      n = 0;
      while (pwr_en_l !== '0 && n < 1500) begin
        step();
        n++;
      end
    end
    chk("stagger_all_on", 32'(pwr_en_l), 32'd0);
    steps(60);
    sample();
    chk("stagger_cnt_done", 32'(spinup_cnt), 32'd0);
    chk("stagger_pend_done", 32'(pend), 32'd0);
    chk("stagger_busy_done", 32'(busy), 32'd0);

    // ---- Round-robin from pointer 5, then immediate off ----
    do_reset();
    req = 15'h0010;             // drive 4 -> pointer becomes 5, one slot used
    exp_q.push_back(4);
    steps(3);
    req = 15'h0218;             // drives 3, 4, 9
    exp_q.push_back(9);
    step();
    sample();
    chk("rr_9_first", 32'(pwr_en_l[9]), 32'd0);
    chk("rr_3_waits", 32'(pwr_en_l[3]), 32'd1);
    steps(3);
    sample();
    chk("rr_full_no_grant", 32'(pwr_en_l[3]), 32'd1);
    chk("rr_full_cnt", 32'(spinup_cnt), 32'd2);
    req = 15'h0208;             // drop drive 4
    exp_q.push_back(3);
    step();
    sample();
    chk("off_pwr_high", 32'(pwr_en_l[4]), 32'd1);
    chk("off_cnt_lag", 32'(spinup_cnt), 32'd2);
    step();
    sample();
    chk("off_cnt_drop", 32'(spinup_cnt), 32'd1);
    chk("off_3_not_yet", 32'(pwr_en_l[3]), 32'd1);
    step();
    sample();
    chk("off_3_granted", 32'(pwr_en_l[3]), 32'd0);

    // ---- Simultaneous events: request drop on grant cycle, TICK on grant ----
    do_reset();
    req = 15'h0060;             // drives 5, 6 fill both slots, pointer -> 7
    exp_q.push_back(5);
    exp_q.push_back(6);
    steps(4);
    req = 15'h0065;             // drives 0, 2 wait
    steps(3);
    sample();
    chk("sim_blocked", 32'(pwr_en_l[2:0]), 32'h7);
    req = 15'h0045;             // drop 5, slot usable two edges later
    steps(2);
    req  = 15'h0044;            // drive 0 falls exactly on the grant edge
    tick = 1'b1;
    exp_q.push_back(2);
    step();
    sample();
    chk("sim_2_granted", 32'(pwr_en_l[2]), 32'd0);
    chk("sim_0_off", 32'(pwr_en_l[0]), 32'd1);
    tick_pulse();
    tick_pulse();
    tick_pulse();
    sample();
    chk("sim_after_3_ticks", 32'(spinup_cnt), 32'd1);
    tick_pulse();
    sample();
    chk("sim_after_4_ticks", 32'(spinup_cnt), 32'd0);

    // ---- Reset mid-spin-up: 5 ON, 2 SPINUP ----
    req = 15'h01C4;             // add 7, 8
    exp_q.push_back(7);
    exp_q.push_back(8);
    steps(4);
    for (int k = 0; k < 4; k++) tick_pulse();
    steps(2);
    req = 15'h05C4;             // add 10
    exp_q.push_back(10);
    steps(3);
    for (int k = 0; k < 4; k++) tick_pulse();
    steps(2);
    req = 15'h1DC4;             // add 11, 12
    exp_q.push_back(11);
    exp_q.push_back(12);
    steps(4);
    sample();
    chk("mid_pre_cnt", 32'(spinup_cnt), 32'd2);
    chk("mid_pre_pwr", 32'(pwr_en_l), 32'(ALL & ~15'h1DC4));
    rst = 1'b1;
    step();
    sample();
    chk("mid_reset_pwr", 32'(pwr_en_l), 32'(ALL));
    chk("mid_reset_cnt", 32'(spinup_cnt), 32'd0);
    rst = 1'b0;
    exp_q.push_back(2);
    exp_q.push_back(6);
    step();
    sample();
    chk("mid_restart_2", 32'(pwr_en_l), 32'h7FFB);
    steps(3);
    sample();
    chk("mid_restart_6", 32'(pwr_en_l), 32'h7FBB);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
